// File: rtl/async_fifo_core_if.sv
// Handshake bundle for async_fifo_core: producer (winc/wdata/wfull) and consumer (rinc/rdata/rempty).
// The occupancy output wlevel exists only when FIFO_LEVEL_EN is defined.
interface async_fifo_core_if #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 4
);
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             wfull;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
`ifdef FIFO_LEVEL_EN
  logic [ASIZE:0]   wlevel;
`endif

  // The master drives requests into the FIFO; the slave is the FIFO itself.
  modport master (
    output wdata, winc, rinc,
    input  wfull, rdata, rempty
`ifdef FIFO_LEVEL_EN
    , input wlevel
`endif
  );

  modport slave (
    input  wdata, winc, rinc,
    output wfull, rdata, rempty
`ifdef FIFO_LEVEL_EN
    , output wlevel
`endif
  );
endinterface

// File: rtl/async_fifo_core.sv
// Single-clock FIFO (2^ASIZE x DSIZE) with separate write/read pointers and first-word-fall-through rdata.
// Define FIFO_LEVEL_EN to add the combinational occupancy output wlevel.
module async_fifo_core #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  async_fifo_core_if.slave    fifo_if
);
  localparam int DEPTH = 1 << ASIZE;

  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic [DSIZE-1:0] mem_q [DEPTH];

  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;
  logic [ASIZE-1:0] waddr;
  logic [ASIZE-1:0] raddr;

  assign waddr = wptr_q[ASIZE-1:0];
  assign raddr = rptr_q[ASIZE-1:0];

  // The extra pointer MSB tells a full FIFO from an empty one when the address bits match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ASIZE] != rptr_q[ASIZE]) && (waddr == raddr);

  // Both requests are qualified by the flags as they stood before the edge.
  assign wr_en = fifo_if.winc && !full && !rst;
  assign rd_en = fifo_if.rinc && !empty && !rst;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; equal pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[waddr] <= fifo_if.wdata;
  end

  always_comb begin
    fifo_if.rdata = '0;
    if (!empty) fifo_if.rdata = mem_q[raddr];
  end

  assign fifo_if.wfull  = full;
  assign fifo_if.rempty = empty;

`ifdef FIFO_LEVEL_EN
  // Modulo subtraction gives 0..DEPTH because the pointers carry one extra bit.
  assign fifo_if.wlevel = wptr_q - rptr_q;
`endif

endmodule

// File: tb/tb_async_fifo_core.sv
// Directed self-checking bench for async_fifo_core: reset, fill/drain, interleave, simultaneous access, wrap and mid-run reset.
// Inputs change 1 ns after the rising edge; outputs are sampled there too, well clear of the next edge.
module tb_async_fifo_core;
  localparam int DSIZE = 32;
  localparam int ASIZE = 4;

  logic clk = 1'b0;
  logic rst;

  int total_cnt = 0;
  int pass_cnt  = 0;

  async_fifo_core_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) fifo_if ();

  async_fifo_core #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk     (clk),
    .rst     (rst),
    .fifo_if (fifo_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fifo_if.winc  = 1'b0;
    fifo_if.rinc  = 1'b0;
    fifo_if.wdata = '0;
  endtask

  task automatic do_reset(input int cycles);
    idle();
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] value);
    fifo_if.winc  = 1'b1;
    fifo_if.wdata = value;
    tick();
    fifo_if.winc  = 1'b0;
  endtask

  // Reads until empty (bounded), checking each head word against base+k, then checks the count.
  task automatic drain_expect(input string tag, input int base, input int n);
    int got = 0;
    for (int k = 0; k < n + 4 && !fifo_if.rempty; k++) begin
      check({tag, "_rdata"}, fifo_if.rdata, 32'(base + k));
      fifo_if.rinc = 1'b1;
      tick();
      fifo_if.rinc = 1'b0;
      got++;
    end
    check({tag, "_count"}, 32'(got), 32'(n));
    check({tag, "_empty"}, {31'd0, fifo_if.rempty}, 32'd1);
  endtask

  initial begin
    idle();

    // Reset state and read-while-empty.
    do_reset(3);
    check("rst_rempty", {31'd0, fifo_if.rempty}, 32'd1);
    check("rst_wfull",  {31'd0, fifo_if.wfull},  32'd0);
    check("rst_rdata",  fifo_if.rdata,           32'd0);
`ifdef FIFO_LEVEL_EN
    check("rst_level",  {27'd0, fifo_if.wlevel}, 32'd0);
`endif
    fifo_if.rinc = 1'b1;
    tick();
    fifo_if.rinc = 1'b0;
    check("underflow_rempty", {31'd0, fifo_if.rempty}, 32'd1);
    check("underflow_rdata",  fifo_if.rdata,           32'd0);

    // Fill to full with 100..85, then one dropped write of 84.
    for (int i = 0; i < 16; i++) begin
      push(32'(100 - i));
      check("fill_rempty", {31'd0, fifo_if.rempty}, 32'd0);
      check("fill_wfull",  {31'd0, fifo_if.wfull},  (i == 15) ? 32'd1 : 32'd0);
    end
`ifdef FIFO_LEVEL_EN
    check("full_level", {27'd0, fifo_if.wlevel}, 32'd16);
`endif
    push(32'd84);
    check("overflow_wfull", {31'd0, fifo_if.wfull}, 32'd1);
    check("overflow_head",  fifo_if.rdata,          32'd100);

    // Drain: 100 down to 85; wfull clears after the first read.
    for (int i = 0; i < 16; i++) begin
      check("drain_rdata", fifo_if.rdata, 32'(100 - i));
      fifo_if.rinc = 1'b1;
      tick();
      fifo_if.rinc = 1'b0;
      check("drain_wfull",  {31'd0, fifo_if.wfull},  32'd0);
      check("drain_rempty", {31'd0, fifo_if.rempty}, (i == 15) ? 32'd1 : 32'd0);
    end
    check("drain_rdata_empty", fifo_if.rdata, 32'd0);

    // Interleaved write-one/read-one with 84..69.
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      push(32'(84 - i));
      check("ilv_rempty_w", {31'd0, fifo_if.rempty}, 32'd0);
      check("ilv_rdata",    fifo_if.rdata,           32'(84 - i));
      check("ilv_wfull_w",  {31'd0, fifo_if.wfull},  32'd0);
      fifo_if.rinc = 1'b1;
      tick();
      fifo_if.rinc = 1'b0;
      check("ilv_rempty_r", {31'd0, fifo_if.rempty}, 32'd1);
      check("ilv_wfull_r",  {31'd0, fifo_if.wfull},  32'd0);
    end

    // Simultaneous at empty: only the write lands.
    fifo_if.winc  = 1'b1;
    fifo_if.rinc  = 1'b1;
    fifo_if.wdata = 32'hA5;
    tick();
    idle();
    check("sim_empty_rempty", {31'd0, fifo_if.rempty}, 32'd0);
    check("sim_empty_rdata",  fifo_if.rdata,           32'hA5);
    drain_expect("sim_empty_drain", 32'hA5, 1);

    // Simultaneous at full: only the read lands, 15 words remain (201..215).
    for (int i = 0; i < 16; i++) push(32'(200 + i));
    check("sim_full_pre", {31'd0, fifo_if.wfull}, 32'd1);
    fifo_if.winc  = 1'b1;
    fifo_if.rinc  = 1'b1;
    fifo_if.wdata = 32'h77;
    tick();
    idle();
    check("sim_full_wfull", {31'd0, fifo_if.wfull}, 32'd0);
`ifdef FIFO_LEVEL_EN
    check("sim_full_level", {27'd0, fifo_if.wlevel}, 32'd15);
`endif
    drain_expect("sim_full_drain", 201, 15);

    // Simultaneous at mid-level (8 words): level unchanged, 301..308 remain.
    for (int i = 0; i < 8; i++) push(32'(300 + i));
    fifo_if.winc  = 1'b1;
    fifo_if.rinc  = 1'b1;
    fifo_if.wdata = 32'd308;
    tick();
    idle();
`ifdef FIFO_LEVEL_EN
    check("sim_mid_level", {27'd0, fifo_if.wlevel}, 32'd8);
`endif
    drain_expect("sim_mid_drain", 301, 8);

    // Wrap: 10 in, 10 out, then 16 in so the address bits wrap.
    do_reset(1);
    for (int i = 0; i < 10; i++) push(32'(i));
    drain_expect("wrap_pre", 0, 10);
    for (int i = 0; i < 16; i++) push(32'(400 + i));
    check("wrap_wfull",  {31'd0, fifo_if.wfull},  32'd1);
    check("wrap_rempty", {31'd0, fifo_if.rempty}, 32'd0);
    drain_expect("wrap_drain", 400, 16);

    // Reset with 5 stored words and concurrent requests.
    for (int i = 0; i < 5; i++) push(32'(500 + i));
    check("mid_rst_pre", fifo_if.rdata, 32'd500);
    fifo_if.winc  = 1'b1;
    fifo_if.rinc  = 1'b1;
    fifo_if.wdata = 32'd999;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("mid_rst_rempty", {31'd0, fifo_if.rempty}, 32'd1);
    check("mid_rst_wfull",  {31'd0, fifo_if.wfull},  32'd0);
    check("mid_rst_rdata",  fifo_if.rdata,           32'd0);
    tick();
    check("post_rst_rempty", {31'd0, fifo_if.rempty}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard time limit in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
